// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with valid/ready handshake,
// flush, optional two-entry skid buffer and saturating profiling counters.
//
// Parameters:
//   DATA_W - width of the stage bundle
//   SKID   - 1: two-entry skid buffer, in_ready from registers only
//            0: single entry, in_ready combinational from out_ready
//   CNT_W  - width of the profiling counters (>= 2)
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   in_valid   - upstream beat valid
//   in_ready   - stage can accept a beat this cycle
//   in_data    - upstream bundle
//   out_valid  - downstream beat valid
//   out_ready  - downstream accepts this cycle
//   out_data   - downstream bundle
//   flush      - discard all held and incoming beats
//   stall_cnt  - cycles with out_valid && !out_ready, saturating
//   drop_cnt   - beats discarded by flush, saturating
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              r_main_v;
  logic [DATA_W-1:0] r_main_d;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_skid_d;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_drop;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [1:0]        w_drop_add;
  logic [CNT_W:0]    w_drop_sum;
  logic [CNT_W-1:0]  w_drop_nxt;

  always_comb begin
    if (SKID != 0) in_ready = rst && !r_skid_v;
    else           in_ready = rst && (!r_main_v || out_ready);
  end

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_main_v && out_ready;
  assign out_valid  = r_main_v;
  assign out_data   = r_main_d;
  assign stall_cnt  = r_stall;
  assign drop_cnt   = r_drop;

  // Beats lost to a flush: the main entry unless it is leaving downstream
  // this cycle, the skid entry, and the beat being accepted right now.
  always_comb begin
    w_drop_add = '0;
    if (flush) begin
      w_drop_add = {1'b0, r_main_v && !w_out_xfer}
                 + {1'b0, r_skid_v}
                 + {1'b0, w_in_xfer};
    end
    w_drop_sum = {1'b0, r_drop} + {{(CNT_W-1){1'b0}}, w_drop_add};
    w_drop_nxt = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_v <= 1'b0;
      r_main_d <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
      r_stall  <= '0;
      r_drop   <= '0;
    end else begin
      if (r_main_v && !out_ready && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
      r_drop <= w_drop_nxt;

      if (flush) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
      end else if (SKID != 0) begin
        if (!r_main_v || out_ready) begin
          // Main is empty or draining: refill from skid first to keep order.
          if (r_skid_v) begin
            r_main_d <= r_skid_d;
            r_main_v <= 1'b1;
            r_skid_v <= 1'b0;
          end else if (w_in_xfer) begin
            r_main_d <= in_data;
            r_main_v <= 1'b1;
          end else begin
            r_main_v <= 1'b0;
          end
        end else if (w_in_xfer) begin
          r_skid_d <= in_data;
          r_skid_v <= 1'b1;
        end
      end else begin
        if (w_in_xfer) begin
          r_main_d <= in_data;
          r_main_v <= 1'b1;
        end else if (w_out_xfer) begin
          r_main_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. Three instances run side by side:
//   0: SKID=1, CNT_W=16   1: SKID=0, CNT_W=16   2: SKID=1, CNT_W=4
// Each is compared every cycle against a FIFO-of-beats model with a
// capacity rule for in_ready and saturating counters.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        out_ready;
  logic        flush;
  logic [2:0]  iv;
  logic [31:0] id   [3];
  logic [2:0]  rdy;
  logic [2:0]  ov;
  logic [31:0] od   [3];
  logic [15:0] sc   [3];
  logic [15:0] dc   [3];
  logic [3:0]  sc2;
  logic [3:0]  dc2;

  assign sc[2] = {12'b0, sc2};
  assign dc[2] = {12'b0, dc2};

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .flush(flush),
    .stall_cnt(sc[0]), .drop_cnt(dc[0]));

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .flush(flush),
    .stall_cnt(sc[1]), .drop_cnt(dc[1]));

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .flush(flush),
    .stall_cnt(sc2), .drop_cnt(dc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model: held beats in arrival order, plus counters.
  int unsigned m_skid [3] = '{1, 0, 1};
  int unsigned m_max  [3] = '{65535, 65535, 15};
  int unsigned m_cnt  [3];
  logic [31:0] m_q    [3][2];
  int unsigned m_stall[3];
  int unsigned m_drop [3];
  bit          m_zero [3];
  int unsigned nxt    [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic src_restart();
    for (int i = 0; i < 3; i++) nxt[i] = 1;
  endtask

  // One clock cycle: drive, check current outputs, advance model, clock.
  task automatic step(input bit en, input bit rnd, input bit ordy, input bit fl,
                      input bit rs, input int unsigned lim);
    bit          e_rdy, inx, outx;
    int unsigned add;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    for (int i = 0; i < 3; i++) begin
      if (rnd) begin
        iv[i] = ($urandom_range(0, 3) != 0);
        id[i] = $urandom;
      end else begin
        iv[i] = en && (nxt[i] <= lim);
        id[i] = nxt[i];
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (m_skid[i] != 0) e_rdy = rs && (m_cnt[i] < 2);
      else                e_rdy = rs && (m_cnt[i] == 0 || ordy);
      chk($sformatf("in_ready[%0d]", i), {63'b0, rdy[i]}, {63'b0, e_rdy});
      chk($sformatf("out_valid[%0d]", i), {63'b0, ov[i]}, {63'b0, m_cnt[i] != 0});
      if (m_cnt[i] != 0)
        chk($sformatf("out_data[%0d]", i), {32'b0, od[i]}, {32'b0, m_q[i][0]});
      else if (m_zero[i])
        chk($sformatf("out_data_rst[%0d]", i), {32'b0, od[i]}, 64'd0);
      chk($sformatf("stall_cnt[%0d]", i), {48'b0, sc[i]}, 64'(m_stall[i]));
      chk($sformatf("drop_cnt[%0d]", i), {48'b0, dc[i]}, 64'(m_drop[i]));

      if (!rs) begin
        m_cnt[i] = 0; m_stall[i] = 0; m_drop[i] = 0; m_zero[i] = 1'b1;
      end else begin
        inx  = iv[i] && e_rdy;
        outx = (m_cnt[i] != 0) && ordy;
        if (m_cnt[i] != 0 && !ordy && m_stall[i] < m_max[i]) m_stall[i]++;
        if (inx) nxt[i]++;
        if (fl) begin
          add = m_cnt[i] - (outx ? 1 : 0) + (inx ? 1 : 0);
          m_drop[i] = (m_drop[i] + add > m_max[i]) ? m_max[i] : m_drop[i] + add;
          m_cnt[i] = 0;
        end else begin
          if (outx) begin
            m_q[i][0] = m_q[i][1];
            m_cnt[i]--;
          end
          if (inx) begin
            m_q[i][m_cnt[i]] = id[i];
            m_cnt[i]++;
            m_zero[i] = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b0; flush = 1'b0; iv = '0;
    for (int i = 0; i < 3; i++) begin
      id[i] = '0; m_cnt[i] = 0; m_stall[i] = 0; m_drop[i] = 0; m_zero[i] = 1'b1;
    end
    src_restart();
    @(negedge clk);

    // Reset, then stream 1..8 at full rate.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 11; k++) step(1, 0, 1, 0, 1, 8);
    chk("stream_stall0", {48'b0, sc[0]}, 64'd0);
    chk("stream_stall1", {48'b0, sc[1]}, 64'd0);

    // Stream 1..6 with a three-cycle downstream stall once beat 2 shows.
    step(0, 0, 1, 0, 0, 0);
    src_restart();
    for (int k = 0; k < 14; k++) step(1, 0, !(k >= 2 && k <= 4), 0, 1, 6);
    chk("bp_stall_skid",   {48'b0, sc[0]}, 64'd3);
    chk("bp_stall_single", {48'b0, sc[1]}, 64'd3);
    chk("bp_all_drained",  {61'b0, ov}, 64'd0);

    // Fill main and skid while stalled, then flush.
    step(0, 0, 0, 0, 0, 0);
    src_restart();
    step(1, 0, 0, 0, 1, 2);
    step(1, 0, 0, 0, 1, 2);
    step(1, 0, 0, 1, 1, 2);
    step(0, 0, 0, 0, 1, 0);
    chk("flush_full_drop", {48'b0, dc[0]}, 64'd2);
    chk("flush_full_ov",   {63'b0, ov[0]}, 64'd0);
    chk("flush_full_rdy",  {63'b0, rdy[0]}, 64'd1);

    // Flush together with an input and an output transfer.
    step(0, 0, 1, 0, 0, 0);
    src_restart();
    step(1, 0, 1, 0, 1, 2);
    step(1, 0, 1, 1, 1, 2);
    step(0, 0, 1, 0, 1, 0);
    chk("flush_xfer_drop0", {48'b0, dc[0]}, 64'd1);
    chk("flush_xfer_drop1", {48'b0, dc[1]}, 64'd1);

    // Long stall: small counter saturates, then reset mid-stall.
    step(0, 0, 0, 0, 0, 0);
    src_restart();
    step(1, 0, 0, 0, 1, 1);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1, 0);
    chk("sat_stall_small", {48'b0, sc[2]}, 64'd15);
    chk("sat_stall_wide",  {48'b0, sc[0]}, 64'd20);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_mid_ov",    {61'b0, ov}, 64'd0);
    chk("rst_mid_stall", {48'b0, sc[2]}, 64'd0);

    // Random traffic, random back-pressure, occasional flush.
    step(0, 0, 1, 0, 1, 0);
    for (int k = 0; k < 400; k++)
      step(0, 1, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, 1, 0);
    // Random traffic with stalls long enough to saturate the small counters.
    for (int k = 0; k < 200; k++)
      step(0, 1, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
